// File: rtl/sensor_pkg.sv
// Shared definitions for the sensor acquisition front end.
//   sampler_state_t : SPI frame sequencer states
//   FRAME_BITS      : SPI frame length in bits
//   CMD_START/CMD_SINGLE : leading command bits of the ADC request word
//   build_cmd()     : assembles the 16-bit command word for a channel
package sensor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } sampler_state_t;

  localparam int   FRAME_BITS = 16;
  localparam logic CMD_START  = 1'b1;
  localparam logic CMD_SINGLE = 1'b1;

  // {start, single-ended, channel[2:0], zero padding}
  function automatic logic [FRAME_BITS-1:0] build_cmd(input logic [2:0] ch);
    return {CMD_START, CMD_SINGLE, ch, {(FRAME_BITS-5){1'b0}}};
  endfunction

endpackage

// File: rtl/adc_spi_sampler_if.sv
// Bundle of the sampler's SPI pins and its result stream.
//   master : the sampler (drives SPI clock/select/MOSI and the result)
//   slave  : the board/ADC side and downstream consumer
//   spi_sclk, spi_cs_n, spi_mosi : SPI outputs of the sampler
//   spi_miso                     : ADC data into the sampler
//   measurement, valid, overrun  : 8-bit result, its strobe, sticky overrun flag
interface adc_spi_sampler_if;
  import sensor_pkg::*;

  logic       spi_sclk;
  logic       spi_cs_n;
  logic       spi_mosi;
  logic       spi_miso;
  logic [7:0] measurement;
  logic       valid;
  logic       overrun;

  modport master (
    output spi_sclk, spi_cs_n, spi_mosi, measurement, valid, overrun,
    input  spi_miso
  );

  modport slave (
    input  spi_sclk, spi_cs_n, spi_mosi, measurement, valid, overrun,
    output spi_miso
  );

endinterface

// File: rtl/sample_timer.sv
// Free-running conversion period timer.
//   clk, rst : clock and asynchronous active-high reset
//   enable   : counts while high, held at zero while low
//   tick     : one-cycle pulse on the last count of each period
module sample_timer
  import sensor_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 10000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!enable || cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = enable && (cnt == CNT_LAST);

endmodule

// File: rtl/adc_spi_sampler.sv
// Periodic SPI mode-0 ADC reader producing an 8-bit truncated sample.
//   clk, rst : clock and asynchronous active-high reset
//   enable   : periodic sampling runs while high
//   bus      : SPI pins (sclk idle low, cs_n active low, mosi MSB first,
//              miso already synchronous to clk) plus measurement/valid/overrun
// A frame is CLK_DIV cycles of chip-select setup followed by 16 SCLK
// periods (high phase then low phase, CLK_DIV cycles each), then one DONE
// cycle in which cs_n returns high and valid pulses.
module adc_spi_sampler
  import sensor_pkg::*;
#(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 10000,
  parameter int ADC_BITS      = 10,
  parameter int CHANNEL       = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  adc_spi_sampler_if.master bus
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]      BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [FRAME_BITS-1:0] CMD      = build_cmd(3'(CHANNEL));

  sampler_state_t   state, state_n;
  logic [DIV_W-1:0] div_cnt, div_n;
  logic [BIT_W-1:0] bit_cnt, bit_n;
  logic             low_phase, low_n;
  logic             tick;
  logic             start;
  logic             capture;
  logic             overrun_set;

  logic [FRAME_BITS-1:0] tx_sr;
  logic [FRAME_BITS-1:0] rx_sr;

  logic       sclk_q;
  logic       cs_n_q;
  logic       mosi_q;
  logic       valid_q;
  logic       overrun_q;
  logic [7:0] meas_q;

  sample_timer #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .enable (enable),
    .tick   (tick)
  );

  // A tick that finds the sequencer busy (including the DONE cycle) is lost.
  assign overrun_set = tick && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div_cnt   <= '0;
      bit_cnt   <= '0;
      low_phase <= 1'b0;
    end else begin
      state     <= state_n;
      div_cnt   <= div_n;
      bit_cnt   <= bit_n;
      low_phase <= low_n;
    end
  end

  always_comb begin
    state_n = state;
    div_n   = div_cnt;
    bit_n   = bit_cnt;
    low_n   = low_phase;
    start   = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE: begin
        if (tick) begin
          state_n = SETUP;
          div_n   = '0;
          start   = 1'b1;
        end
      end
      SETUP: begin
        if (div_cnt == DIV_LAST) begin
          state_n = SHIFT;
          div_n   = '0;
          bit_n   = '0;
          low_n   = 1'b0;
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_n = '0;
          if (!low_phase) begin
            // End of the high phase: sample MISO, SCLK falls, MOSI advances.
            capture = 1'b1;
            low_n   = 1'b1;
          end else begin
            low_n = 1'b0;
            if (bit_cnt == BIT_LAST) begin
              state_n = DONE;
            end else begin
              bit_n = bit_cnt + 1'b1;
            end
          end
        end else begin
          div_n = div_cnt + 1'b1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // Pin and result registers are decoded from the next state so every
  // output is a clean flop aligned with the state it belongs to.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_q    <= 1'b0;
      cs_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      meas_q    <= '0;
    end else begin
      sclk_q  <= (state_n == SHIFT) && !low_n;
      cs_n_q  <= !((state_n == SETUP) || (state_n == SHIFT));
      valid_q <= (state_n == DONE);
      if (state_n == DONE) begin
        // Keep the top 8 of the ADC_BITS result; low bits are dropped.
        meas_q <= rx_sr[ADC_BITS-1 -: 8];
      end
      if (start) begin
        mosi_q <= CMD[FRAME_BITS-1];
      end else if (capture) begin
        mosi_q <= tx_sr[FRAME_BITS-1];
      end
      if (overrun_set) begin
        overrun_q <= 1'b1;
      end
    end
  end

  // Shift registers carry data only; their contents are fully rewritten
  // every frame before use, so they need no reset.
  always_ff @(posedge clk) begin
    if (start) begin
      tx_sr <= {CMD[FRAME_BITS-2:0], 1'b0};
    end else if (capture) begin
      tx_sr <= {tx_sr[FRAME_BITS-2:0], 1'b0};
    end
    if (capture) begin
      rx_sr <= {rx_sr[FRAME_BITS-2:0], bus.spi_miso};
    end
  end

  assign bus.spi_sclk    = sclk_q;
  assign bus.spi_cs_n    = cs_n_q;
  assign bus.spi_mosi    = mosi_q;
  assign bus.valid       = valid_q;
  assign bus.overrun     = overrun_q;
  assign bus.measurement = meas_q;

endmodule

// File: tb/tb_adc_spi_sampler.sv
// Directed bench for adc_spi_sampler with three parameterisations:
//   A: defaults (CLK_DIV=4, SAMPLE_PERIOD=10000, ADC_BITS=10, CHANNEL=0)
//   B: SAMPLE_PERIOD=300, ADC_BITS=12, CHANNEL=5
//   C: SAMPLE_PERIOD=100 (shorter than a frame, to provoke overrun)
// Cycle numbering: the cycle in which enable is raised is cycle 1.
module tb_adc_spi_sampler;

  localparam int SP_A  = 10000;
  localparam int SP_B  = 300;
  localparam int SP_C  = 100;
  localparam int LAT   = 133;
  localparam int CS_LO = 132;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  logic en_c = 1'b0;

  always #5 clk = ~clk;

  adc_spi_sampler_if ba ();
  adc_spi_sampler_if bb ();
  adc_spi_sampler_if bc ();

  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(SP_A), .ADC_BITS(10), .CHANNEL(0))
    dut_a (.clk(clk), .rst(rst), .enable(en_a), .bus(ba));
  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(SP_B), .ADC_BITS(12), .CHANNEL(5))
    dut_b (.clk(clk), .rst(rst), .enable(en_b), .bus(bb));
  adc_spi_sampler #(.CLK_DIV(4), .SAMPLE_PERIOD(SP_C), .ADC_BITS(10), .CHANNEL(0))
    dut_c (.clk(clk), .rst(rst), .enable(en_c), .bus(bc));

  logic       sclk_v [3];
  logic       cs_v   [3];
  logic       mosi_v [3];
  logic       valid_v[3];
  logic       ovr_v  [3];
  logic [7:0] meas_v [3];
  logic       miso_r [3];

  assign sclk_v[0] = ba.spi_sclk;  assign sclk_v[1] = bb.spi_sclk;  assign sclk_v[2] = bc.spi_sclk;
  assign cs_v[0]   = ba.spi_cs_n;  assign cs_v[1]   = bb.spi_cs_n;  assign cs_v[2]   = bc.spi_cs_n;
  assign mosi_v[0] = ba.spi_mosi;  assign mosi_v[1] = bb.spi_mosi;  assign mosi_v[2] = bc.spi_mosi;
  assign valid_v[0] = ba.valid;    assign valid_v[1] = bb.valid;    assign valid_v[2] = bc.valid;
  assign ovr_v[0]  = ba.overrun;   assign ovr_v[1]  = bb.overrun;   assign ovr_v[2]  = bc.overrun;
  assign meas_v[0] = ba.measurement; assign meas_v[1] = bb.measurement; assign meas_v[2] = bc.measurement;
  assign ba.spi_miso = miso_r[0];
  assign bb.spi_miso = miso_r[1];
  assign bc.spi_miso = miso_r[2];

  // ADC model: after the k-th SCLK rise of a frame, MISO presents bit
  // (16-k) of the 16-bit frame word. It also records what the DUT sent.
  logic [15:0] frame_w  [3];
  logic [15:0] mosi_sr  [3];
  logic [15:0] mosi_done[3];
  int          rise_cnt [3];
  int          low_cnt  [3];
  int          rises_done[3];
  int          low_done [3];
  logic        prev_sclk[3];
  logic        prev_cs  [3];

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (!cs_v[i]) begin
        low_cnt[i] = low_cnt[i] + 1;
        if (sclk_v[i] && !prev_sclk[i]) begin
          rise_cnt[i] = rise_cnt[i] + 1;
          mosi_sr[i]  = {mosi_sr[i][14:0], mosi_v[i]};
        end
      end else if (!prev_cs[i]) begin
        rises_done[i] = rise_cnt[i];
        low_done[i]   = low_cnt[i];
        mosi_done[i]  = mosi_sr[i];
        rise_cnt[i]   = 0;
        low_cnt[i]    = 0;
        mosi_sr[i]    = 16'h0;
      end
      if (rise_cnt[i] > 0 && rise_cnt[i] <= 16) begin
        logic [3:0] bi;
        bi = 4'(16 - rise_cnt[i]);
        miso_r[i] = frame_w[i][bi];
      end else begin
        miso_r[i] = 1'b0;
      end
      prev_sclk[i] = sclk_v[i];
      prev_cs[i]   = cs_v[i];
    end
  end

  typedef struct {
    logic [15:0] miso;
    logic [7:0]  meas;
  } vec_t;

  vec_t tbl[5];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_valid(input int i, input int budget, input string nm);
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!valid_v[i] && k < budget);
    if (!valid_v[i]) begin
      total++;
      bad++;
      $display("FAIL %s: no valid within %0d cycles", nm, budget);
    end
  endtask

  task automatic wait_cs_low(input int i, input int budget, input string nm);
    int k;
    k = 0;
    while (cs_v[i] && k < budget) begin
      step();
      k++;
    end
    if (cs_v[i]) begin
      total++;
      bad++;
      $display("FAIL %s: cs_n never went low within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int tlast;
    int cnt;

    for (int i = 0; i < 3; i++) begin
      frame_w[i] = 16'h0; mosi_sr[i] = 16'h0; mosi_done[i] = 16'h0;
      rise_cnt[i] = 0; low_cnt[i] = 0; rises_done[i] = 0; low_done[i] = 0;
      prev_sclk[i] = 1'b0; prev_cs[i] = 1'b1; miso_r[i] = 1'b0;
    end
    tbl[0] = '{16'h0FFF, 8'hFF};
    tbl[1] = '{16'h000F, 8'h00};
    tbl[2] = '{16'h0A5C, 8'hA5};
    tbl[3] = '{16'h0123, 8'h12};
    tbl[4] = '{16'h0800, 8'h80};

    // Reset values
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst_sclk", 32'(ba.spi_sclk), 32'd0);
    chk("rst_cs_n", 32'(ba.spi_cs_n), 32'd1);
    chk("rst_mosi", 32'(ba.spi_mosi), 32'd0);
    chk("rst_meas", 32'(ba.measurement), 32'd0);
    chk("rst_valid", 32'(ba.valid), 32'd0);
    chk("rst_overrun", 32'(ba.overrun), 32'd0);
    chk("rst_cs_n_b", 32'(bb.spi_cs_n), 32'd1);
    chk("rst_cs_n_c", 32'(bc.spi_cs_n), 32'd1);

    // A: default parameters, 10-bit 0x2C5 -> 0xB1
    frame_w[0] = 16'h02C5;
    en_a = 1'b1;
    t0 = cyc;
    wait_valid(0, SP_A + 200, "a_first_valid");
    chk("a_latency", 32'(cyc - t0 + 1), 32'(SP_A + LAT));
    chk("a_meas", 32'(meas_v[0]), 32'hB1);
    chk("a_rises", 32'(rises_done[0]), 32'd16);
    chk("a_cs_low", 32'(low_done[0]), 32'(CS_LO));
    chk("a_mosi", 32'(mosi_done[0]), 32'hC000);
    tlast = cyc;
    frame_w[0] = 16'h03FF;
    step();
    chk("a_valid_pulse", 32'(valid_v[0]), 32'd0);
    chk("a_meas_held", 32'(meas_v[0]), 32'hB1);
    wait_valid(0, SP_A + 10, "a_second_valid");
    chk("a_spacing", 32'(cyc - tlast), 32'(SP_A));
    chk("a_meas2", 32'(meas_v[0]), 32'hFF);
    en_a = 1'b0;

    // C: period shorter than a frame -> overrun, data still correct
    frame_w[2] = 16'h01AB;
    en_c = 1'b1;
    t0 = cyc;
    while (cyc - t0 + 1 < 150) step();
    chk("c_ovr_150", 32'(ovr_v[2]), 32'd0);
    while (cyc - t0 + 1 < 200) step();
    chk("c_ovr_200", 32'(ovr_v[2]), 32'd0);
    step();
    chk("c_ovr_201", 32'(ovr_v[2]), 32'd1);
    wait_valid(2, 100, "c_first_valid");
    chk("c_valid_cycle", 32'(cyc - t0 + 1), 32'd233);
    chk("c_meas", 32'(meas_v[2]), 32'h6A);
    tlast = cyc;
    frame_w[2] = 16'h03C0;
    wait_valid(2, 2 * SP_C + 10, "c_second_valid");
    chk("c_spacing", 32'(cyc - tlast), 32'(2 * SP_C));
    chk("c_meas2", 32'(meas_v[2]), 32'hF0);
    chk("c_ovr_sticky", 32'(ovr_v[2]), 32'd1);
    en_c = 1'b0;

    // B: table of frames, 12-bit ADC, channel 5
    frame_w[1] = tbl[0].miso;
    en_b = 1'b1;
    t0 = cyc;
    tlast = cyc;
    for (int i = 0; i < 5; i++) begin
      wait_valid(1, SP_B + 200, "b_tbl_valid");
      if (i == 0) chk("b_latency", 32'(cyc - t0 + 1), 32'(SP_B + LAT));
      else        chk("b_spacing", 32'(cyc - tlast), 32'(SP_B));
      chk("b_meas", 32'(meas_v[1]), 32'(tbl[i].meas));
      chk("b_mosi", 32'(mosi_done[1]), 32'hE800);
      chk("b_rises", 32'(rises_done[1]), 32'd16);
      chk("b_cs_low", 32'(low_done[1]), 32'(CS_LO));
      tlast = cyc;
      if (i < 4) frame_w[1] = tbl[i + 1].miso;
      step();
      chk("b_valid_pulse", 32'(valid_v[1]), 32'd0);
      chk("b_meas_held", 32'(meas_v[1]), 32'(tbl[i].meas));
    end

    // B: enable dropped mid-frame
    frame_w[1] = 16'h0ABC;
    wait_cs_low(1, SP_B, "b_drop_cs");
    repeat (20) step();
    en_b = 1'b0;
    wait_valid(1, 200, "b_drop_valid");
    chk("b_drop_meas", 32'(meas_v[1]), 32'hAB);
    cnt = 0;
    for (int k = 0; k < 2 * SP_B; k++) begin
      step();
      if (!cs_v[1]) cnt++;
    end
    chk("b_drop_quiet", 32'(cnt), 32'd0);
    frame_w[1] = 16'h0567;
    en_b = 1'b1;
    t0 = cyc;
    wait_valid(1, SP_B + 200, "b_reenable_valid");
    chk("b_reenable_lat", 32'(cyc - t0 + 1), 32'(SP_B + LAT));
    chk("b_reenable_meas", 32'(meas_v[1]), 32'h56);

    // B: reset at cycle 60 of a frame
    wait_cs_low(1, SP_B, "b_rst_cs");
    for (int k = 1; k < 60; k++) step();
    rst = 1'b1;
    en_b = 1'b0;
    #1;
    chk("b_rst_cs_n", 32'(cs_v[1]), 32'd1);
    chk("b_rst_sclk", 32'(sclk_v[1]), 32'd0);
    chk("b_rst_valid", 32'(valid_v[1]), 32'd0);
    step();
    rst = 1'b0;
    cnt = 0;
    for (int k = 0; k < 200; k++) begin
      step();
      if (valid_v[1]) cnt++;
    end
    chk("b_rst_no_valid", 32'(cnt), 32'd0);
    frame_w[1] = 16'h05A0;
    en_b = 1'b1;
    t0 = cyc;
    wait_valid(1, SP_B + 200, "b_after_rst_valid");
    chk("b_after_rst_lat", 32'(cyc - t0 + 1), 32'(SP_B + LAT));
    chk("b_after_rst_meas", 32'(meas_v[1]), 32'h5A);
    chk("b_after_rst_rises", 32'(rises_done[1]), 32'd16);
    chk("b_after_rst_mosi", 32'(mosi_done[1]), 32'hE800);
    chk("b_no_overrun", 32'(ovr_v[1]), 32'd0);
    en_b = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/adc_spi_sampler.md
# adc_spi_sampler

Front-end acquisition stage for the sensor filter chain. It periodically reads one channel of an external SPI ADC in SPI mode 0 and reduces the sample to 8 bits. Each completed conversion produces a one-cycle `valid` pulse with `measurement`, which connects directly to the Kalman filter's `valid`/`measurement` inputs. The block has no backpressure: the downstream stage accepts every pulse.

## Interface
- `CLK_DIV`, 4: clk cycles per SCLK half-period; must be ≥2.
- `SAMPLE_PERIOD`, 10000: clk cycles between conversion starts; must be ≥ 33*CLK_DIV+2.
- `ADC_BITS`, 10: ADC resolution, 8..12; result is the last ADC_BITS MISO bits of the frame.
- `CHANNEL`, 0: ADC input channel, 0..7.
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  high = periodic sampling runs.
- `spi_sclk`  out  1  SPI clock; idle low.
- `spi_cs_n`  out  1  ADC chip select; active low.
- `spi_mosi`  out  1  command bit, MSB first.
- `spi_miso`  in  1  ADC data; already synchronous to clk (board-level requirement).
- `measurement`  out  8  top 8 bits of the ADC result; held until the next `valid`.
- `valid`  out  1  one-cycle pulse when `measurement` updates.
- `overrun`  out  1  sticky; set when a sample tick arrives during a frame; cleared only by `rst`.

## Operation
- Reset values: `spi_sclk`=0, `spi_cs_n`=1, `spi_mosi`=0, `measurement`=0, `valid`=0, `overrun`=0, tick counter=0, FSM=IDLE.
- Tick counter:
  - Counts 0..SAMPLE_PERIOD-1 while `enable`=1 and emits `tick` at SAMPLE_PERIOD-1, then wraps to 0.
  - While `enable`=0 it holds at 0.
- Frame: 16 bits. Command word = {1'b1 start, 1'b1 single-ended, CHANNEL[2:0], 11'b0}.
- FSM:
  - IDLE: on `tick`, go to SETUP, drive cs_n low, drive mosi = cmd[15].
  - SETUP: lasts CLK_DIV cycles, then go to SHIFT.
  - SHIFT: 16 SCLK periods. Each period is a high phase of CLK_DIV cycles followed by a low phase of CLK_DIV cycles.
    - MISO is captured into a 16-bit shift register on the last clk cycle of each high phase.
    - MOSI advances to the next command bit when SCLK falls.
    - After the 16th low phase, go to DONE.
  - DONE: 1 cycle. Drive cs_n high and `valid`=1. `measurement` = rx[ADC_BITS-1 -: 8]. Return to IDLE.
- A `tick` in any state other than IDLE is dropped and sets `overrun`. A `tick` in the DONE cycle also counts as an overrun.
- `enable` falling mid-frame: the frame completes normally and `valid` still fires; no new frame starts.
- `rst` mid-frame: outputs return to reset values immediately (cs_n high, sclk low) and no `valid` is issued.
- Truncation, not rounding: the low ADC_BITS-8 bits are discarded.

## Timing
- `tick` in cycle T gives cs_n low in T+1 and `valid` in T+1+CLK_DIV+32*CLK_DIV, i.e. latency 33*CLK_DIV+1 cycles (133 with defaults).
- cs_n is low for exactly 33*CLK_DIV cycles and returns high in the same cycle `valid` is high.
- `measurement` changes only in the `valid` cycle and is stable between pulses.
- Successive `valid` pulses are exactly SAMPLE_PERIOD cycles apart while `enable` stays high.

## Structure
- Shared package `sensor_pkg` holds:
  - FSM state typedef (IDLE, SETUP, SHIFT, DONE);
  - FRAME_BITS=16;
  - command start/single-ended bit constants.
- One sub-module, `sample_timer`: the SAMPLE_PERIOD counter with `enable`, producing `tick`.
- The SCLK divider, bit counter and shift registers stay in the top module.

## Test plan
- Reset, then `enable`=1 with defaults and a MISO model returning 10-bit 0x2C5 → first `valid` at cycle SAMPLE_PERIOD+133 after enable, `measurement`=0xB1, exactly 16 SCLK rising edges while cs_n is low.
- CHANNEL=5 → MOSI sampled on SCLK rising edges reads 0xE800.
- ADC_BITS=12, MISO returns 0xFFF, then 0x00F → `measurement`=0xFF, then 0x00.
- SAMPLE_PERIOD=100 with CLK_DIV=4 → `overrun` rises at the first tick inside a frame and stays 1; every `valid` still carries correct data.
- Assert `rst` for one cycle at cycle 60 of a frame → cs_n=1 and sclk=0 immediately, no `valid`; the next frame after re-enable is correct.
- Drop `enable` mid-frame → that frame's `valid` fires, then no further cs_n activity; re-enable gives the next `valid` SAMPLE_PERIOD+133 cycles later.
